registers_unit: RTL and testbench
=================================

// Module: registers_unit
// PURPOSE
//   RV32I integer register file: 32 x 32-bit registers (x0..x31) with two combinational read ports
//   (rs1, rs2) and one synchronous write port (rd).
//   Sits in the decode stage of the single-cycle core. Operands feed the ALU; the write-back value
//   comes from the WB mux.
//   x0 is hardwired to zero.
// PARAMETERS
//   XLEN    32   data width of each register and of DataWr/o_rs1/o_rs2
//   NREGS   32   number of architectural registers
//   AW      5    register address width; must equal clog2(NREGS)
// PORTS
//   Clk     in   1     single clock; all state updates on rising edge
//   Rst     in   1     synchronous, active-high reset, sampled on rising edge of Clk
//   rs1     in   AW    read address, port 1
//   rs2     in   AW    read address, port 2
//   rd      in   AW    write address
//   DataWr  in   XLEN  write data
//   RUWr    in   1     write enable, active high
//   o_rs1   out  XLEN  contents of register rs1 (combinational)
//   o_rs2   out  XLEN  contents of register rs2 (combinational)
// BEHAVIOUR
//   - Storage: NREGS x XLEN flops. Entry 0 is never written and always reads 0.
//   - Reset:
//     - Rst=1 at a rising edge clears every register to 32'h0000_0000.
//     - Reset has priority over any write in the same cycle.
//     - While Rst is high, o_rs1/o_rs2 read 0 after the first reset edge.
//     - Reset asserted mid-operation discards all prior contents.
//   - Write:
//     - On a rising edge with Rst=0, RUWr=1 and rd!=0: reg[rd] <= DataWr.
//     - RUWr=1 with rd==0: no state change.
//     - RUWr=0: no state change regardless of rd/DataWr.
//   - Read:
//     - o_rs1 = (rs1==0) ? 0 : reg[rs1].
//     - o_rs2 = (rs2==0) ? 0 : reg[rs2].
//     - Purely combinational: zero-cycle latency from an address change.
//   - Read-during-write, same address:
//     - No internal bypass. Before the edge the read returns the old value.
//     - After the edge it returns DataWr.
//     - Forwarding, if needed, is done outside this block.
//   - rs1==rs2 is legal; both outputs show the same value.
//   - Both read ports and the write port are independent: any combination in one cycle is legal.
//   - Power-up contents before the first reset are undefined.
//   - Exception: the x0 read path returns 0 at all times.
//   - No X propagation from x0: its read is a constant, not a flop output.
// TESTING
//   1. Rst=1 for 1 edge, then Rst=0; read rs1=5, rs2=31 -> o_rs1=0, o_rs2=0.
//   2. rd=0, DataWr=123, RUWr=1 for one edge; RUWr=0, rs1=0 -> o_rs1=0 (x0 immutable).
//   3. rd=5, DataWr=45, RUWr=1 for one edge; RUWr=0, rs1=5 -> o_rs1=45.
//   4. rd=10, DataWr=100, RUWr=1 for one edge; rs1=5, rs2=10 -> o_rs1=45, o_rs2=100 simultaneously.
//   5. Write-enable gating: rd=10, DataWr=200, RUWr=0 for one edge; rs1=10 -> o_rs1=100 (unchanged).
//   6. Reset priority and read-during-write:
//      - rd=7, DataWr=32'hDEAD_BEEF, RUWr=1, rs1=7:
//        o_rs1 = old value before the edge, 32'hDEAD_BEEF after it.
//      - Then Rst=1 with RUWr=1, rd=7, DataWr=9 at one edge -> o_rs1=0 and x5/x10 read 0.

Source files
------------

// File: rtl/registers_unit.sv
// -----------------------------------------------------------------------------
// registers_unit
//   RV32I integer register file for the decode stage of the single-cycle core.
//   It holds 32 x 32-bit architectural registers (x0..x31) and has:
//     - two combinational read ports (rs1, rs2), which feed the ALU operands;
//     - one synchronous write port (rd), which takes data from the WB mux.
//   x0 is not stored. Its read path is the constant zero.
//
// Parameters
//   XLEN   data width of each register and of DataWr/o_rs1/o_rs2
//   NREGS  number of architectural registers
//   AW     register address width; must equal clog2(NREGS)
//
// Ports
//   Clk     in   1     single clock; all state updates happen on the rising edge
//   Rst     in   1     synchronous active-high reset; clears every register
//   rs1     in   AW    read address, port 1
//   rs2     in   AW    read address, port 2
//   rd      in   AW    write address
//   DataWr  in   XLEN  write data
//   RUWr    in   1     write enable, active high
//   o_rs1   out  XLEN  contents of register rs1 (combinational)
//   o_rs2   out  XLEN  contents of register rs2 (combinational)
//
// Notes
//   - There is no read-during-write bypass. A read of the register being
//     written returns the old value until the edge. Any forwarding is done
//     outside this block.
//   - The read ports are intentionally combinational so that operands have
//     zero-cycle latency from an address change.
// -----------------------------------------------------------------------------
module registers_unit #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] DataWr,
    input  logic            RUWr,
    output logic [XLEN-1:0] o_rs1,
    output logic [XLEN-1:0] o_rs2
);

    // Only x1..x(NREGS-1) are real flops. x0 has no storage, so its read
    // can never leak an X or a stale value.
    logic [XLEN-1:0] regs_r [NREGS-1:1];

    // A write takes effect only for a non-zero destination.
    logic            wr_en_s;

    // Qualify the write enable. A write to x0 is dropped.
    always_comb begin
        wr_en_s = 1'b0;
        if (RUWr && (rd != {AW{1'b0}})) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Register storage. Reset takes priority over a write in the same cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[rd] <= DataWr;
        end
    end

    // Read port 1. Address 0 decodes to the constant zero.
    always_comb begin
        o_rs1 = {XLEN{1'b0}};
        if (rs1 == {AW{1'b0}}) begin
            o_rs1 = {XLEN{1'b0}};
        end else begin
            o_rs1 = regs_r[rs1];
        end
    end

    // Read port 2. Address 0 decodes to the constant zero.
    always_comb begin
        o_rs2 = {XLEN{1'b0}};
        if (rs2 == {AW{1'b0}}) begin
            o_rs2 = {XLEN{1'b0}};
        end else begin
            o_rs2 = regs_r[rs2];
        end
    end

endmodule

// File: tb/tb_registers_unit.sv
// -----------------------------------------------------------------------------
// tb_registers_unit
//   Self-checking bench for registers_unit.
//   The reference model is a plain 32-entry array. It is updated at each
//   rising edge from the inputs presented during that cycle.
//   The bench runs directed scenarios first, then randomized traffic. Inputs
//   change on the falling edge. Reads are checked #1 after the inputs change
//   (pre-edge value) and #1 after the rising edge (post-edge value).
// -----------------------------------------------------------------------------
module tb_registers_unit;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] data_wr;
    logic        ru_wr;
    logic [31:0] o_rs1;
    logic [31:0] o_rs2;

    int unsigned model [32];
    int          n_checks;
    int          n_fails;

    registers_unit #(
        .XLEN  (32),
        .NREGS (32),
        .AW    (5)
    ) dut (
        .Clk    (clk),
        .Rst    (rst),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd     (rd),
        .DataWr (data_wr),
        .RUWr   (ru_wr),
        .o_rs1  (o_rs1),
        .o_rs2  (o_rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison, and report it if it failed.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural read: x0 is zero, any other register is its stored value.
    function automatic logic [31:0] arch_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    // Present one cycle's inputs on the falling edge.
    task automatic drive(input logic r, input logic we, input logic [4:0] a_rd,
                         input logic [31:0] d, input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        rst     = r;
        ru_wr   = we;
        rd      = a_rd;
        data_wr = d;
        rs1     = a1;
        rs2     = a2;
        #1;
    endtask

    // Clock one rising edge and update the model from this cycle's inputs.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (ru_wr && rd != 5'd0) begin
            model[rd] = data_wr;
        end
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b1; ru_wr = 1'b0; rd = 5'd0; data_wr = 32'h0; rs1 = 5'd0; rs2 = 5'd0;

        // Before any reset, x0 still reads zero.
        #1;
        check_eq("x0_before_reset", o_rs1, 32'h0);

        // 1. Reset, then read x5 and x31.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        tick();
        check_eq("reset_hold_rs1", o_rs1, 32'h0);
        check_eq("reset_hold_rs2", o_rs2, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        check_eq("reset_x5", o_rs1, 32'h0);
        check_eq("reset_x31", o_rs2, 32'h0);

        // 2. A write to x0 is ignored.
        drive(1'b0, 1'b1, 5'd0, 32'd123, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        check_eq("x0_immutable", o_rs1, 32'h0);

        // 3. Write x5 and read it back.
        drive(1'b0, 1'b1, 5'd5, 32'd45, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        check_eq("x5_write", o_rs1, 32'd45);

        // 4. Write x10, then read x5 and x10 at the same time.
        drive(1'b0, 1'b1, 5'd10, 32'd100, 5'd5, 5'd10);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd10);
        check_eq("dual_rs1_x5", o_rs1, 32'd45);
        check_eq("dual_rs2_x10", o_rs2, 32'd100);

        // 5. With RUWr low, the register is not written.
        drive(1'b0, 1'b0, 5'd10, 32'd200, 5'd10, 5'd10);
        tick();
        check_eq("we_gating", o_rs1, 32'd100);
        check_eq("same_addr_both", o_rs2, 32'd100);

        // 6. Read-during-write returns the old value before the edge and the
        //    new value after it.
        drive(1'b0, 1'b1, 5'd7, 32'h0BAD_F00D, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7);
        check_eq("rdw_pre_edge", o_rs1, 32'h0BAD_F00D);
        tick();
        check_eq("rdw_post_edge", o_rs1, 32'hDEAD_BEEF);

        // Reset has priority over a write in the same cycle.
        drive(1'b1, 1'b1, 5'd7, 32'd9, 5'd7, 5'd5);
        tick();
        check_eq("rst_prio_x7", o_rs1, 32'h0);
        check_eq("rst_clear_x5", o_rs2, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd7);
        check_eq("rst_clear_x10", o_rs1, 32'h0);
        check_eq("rst_clear_x7", o_rs2, 32'h0);

        // Randomized traffic, checked against the array model.
        for (int n = 0; n < 3000; n++) begin
            logic        r;
            logic        we;
            logic [4:0]  a_rd;
            logic [4:0]  a1;
            logic [4:0]  a2;
            logic [31:0] d;
            r    = ($urandom_range(0, 99) == 0);
            we   = ($urandom_range(0, 3) != 0);
            a_rd = 5'($urandom_range(0, 31));
            a1   = ($urandom_range(0, 3) == 0) ? a_rd : 5'($urandom_range(0, 31));
            a2   = ($urandom_range(0, 7) == 0) ? a1 : 5'($urandom_range(0, 31));
            d    = $urandom;
            drive(r, we, a_rd, d, a1, a2);
            check_eq("rand_pre_rs1", o_rs1, arch_read(rs1));
            check_eq("rand_pre_rs2", o_rs2, arch_read(rs2));
            tick();
            check_eq("rand_post_rs1", o_rs1, arch_read(rs1));
            check_eq("rand_post_rs2", o_rs2, arch_read(rs2));
        end

        // Final sweep of every register through both ports.
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a));
            check_eq("sweep_rs1", o_rs1, arch_read(5'(a)));
            check_eq("sweep_rs2", o_rs2, arch_read(5'(31 - a)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
